work_mem_arbiter: RTL and testbench

Arbitrates the single-port 32-bit working-buffer SRAM between up to NUM_REQ processing engines: MDCT transform, spectral analysis, quantizer and bitstream packer. Each engine uses a valid/ready request port. Arbitration is round-robin, with an optional lock so an engine can own the memory for a burst. Read data is routed back to the engine that issued the read after the fixed SRAM latency. The block sits between the processing engines and the shared work memory macro.

---
 rtl/codec_pkg.sv | 13 +
 rtl/work_mem_arbiter_if.sv | 19 +
 rtl/rr_priority_pick.sv | 22 ++
 rtl/work_mem_arbiter.sv | 98 +++++++++
 tb/tb_work_mem_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: requester ids, arbiter state encodings and work-memory region bases shared by the codec engines.
package codec_pkg;
  localparam int ID_W = 3;
  localparam logic [ID_W-1:0] REQ_MDCT  = 3'd0;
  localparam logic [ID_W-1:0] REQ_SPEC  = 3'd1;
  localparam logic [ID_W-1:0] REQ_QUANT = 3'd2;
  localparam logic [ID_W-1:0] REQ_PACK  = 3'd3;
  typedef enum logic {ARB_ST = 1'b0, LOCK_ST = 1'b1} arb_state_e;
  localparam logic [11:0] MDCT_BASE  = 12'h000;
  localparam logic [11:0] SPEC_BASE  = 12'h400;
  localparam logic [11:0] QUANT_BASE = 12'h800;
  localparam logic [11:0] PACK_BASE  = 12'hC00;
endpackage

// File: rtl/work_mem_arbiter_if.sv
// work_mem_arbiter_if: engine-side request/response bundle of the work-memory arbiter.
interface work_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_wen;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  modport master (output req_valid, req_addr, req_wdata, req_wen, req_lock,
                  input req_ready, rsp_valid, rsp_rdata);
  modport slave (input req_valid, req_addr, req_wdata, req_wen, req_lock,
                 output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin selector; first set request at or above ptr (wrapping) wins.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/work_mem_arbiter.sv
// work_mem_arbiter: round-robin arbiter with burst lock for the shared work SRAM; routes read data back by id.
module work_mem_arbiter
  import codec_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_enable,
  work_mem_arbiter_if.slave  bus,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               arb_busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               lock_timeout
);
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam int PW  = RD_LAT * IW;
  arb_state_e state, nxt_state;
  logic [IW-1:0] rr_ptr, nxt_ptr, owner, nxt_owner, pk_idx, gnt_idx;
  logic [LCW-1:0] lock_cnt, nxt_cnt;
  logic [NUM_REQ-1:0] pk_gnt, ready;
  logic acc, sel_wen, sel_lock, to_set;
  logic [RD_LAT-1:0] pv;
  logic [PW-1:0] pid;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(bus.req_valid), .ptr(rr_ptr), .gnt(pk_gnt), .idx(pk_idx)
  );
  always_comb begin
    ready = '0;
    gnt_idx = (state == LOCK_ST) ? owner : pk_idx;
    if (state == LOCK_ST) ready[owner] = bus.req_valid[owner] & arb_enable;
    else if (arb_enable) ready = pk_gnt;
  end
  assign acc        = |ready;
  assign sel_wen    = bus.req_wen[gnt_idx];
  assign sel_lock   = bus.req_lock[gnt_idx];
  assign bus.req_ready = ready;
  assign sram_cs    = acc;
  assign sram_we    = acc & sel_wen;
  assign sram_addr  = acc ? bus.req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
  assign sram_wdata = acc ? bus.req_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
  always_comb begin
    nxt_state = state;
    nxt_ptr = rr_ptr;
    nxt_owner = owner;
    nxt_cnt = lock_cnt;
    to_set = 1'b0;
    if (state == ARB_ST) begin
      if (acc && sel_lock) begin
        nxt_state = LOCK_ST;
        nxt_owner = gnt_idx;
        nxt_cnt = LCW'(1);
      end else if (acc) nxt_ptr = inc(gnt_idx);
    end else if (lock_cnt == LCW'(LOCK_MAX) || (acc && !sel_lock)) begin
      nxt_state = ARB_ST;
      nxt_ptr = inc(owner);
      nxt_cnt = '0;
      to_set = lock_cnt == LCW'(LOCK_MAX);
    end else nxt_cnt = lock_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_ST;
      rr_ptr <= '0;
      owner <= '0;
      lock_cnt <= '0;
      grant_id <= '0;
      lock_timeout <= 1'b0;
      pv <= '0;
      pid <= '0;
    end else begin
      state <= nxt_state;
      rr_ptr <= nxt_ptr;
      owner <= nxt_owner;
      lock_cnt <= nxt_cnt;
      grant_id <= acc ? ID_W'(gnt_idx) : grant_id;
      lock_timeout <= lock_timeout | to_set;
      pv <= RD_LAT'({pv, acc & ~sel_wen});
      pid <= PW'({pid, gnt_idx});
    end
  end
  // the pipe tail lines up with sram_rdata for the read issued RD_LAT cycles ago
  assign bus.rsp_valid = pv[RD_LAT-1] ? NUM_REQ'(1) << pid[PW-1 -: IW] : '0;
  assign bus.rsp_rdata = pv[RD_LAT-1] ? sram_rdata : '0;
  assign arb_busy      = (state == LOCK_ST) | (|pv);
endmodule

// File: tb/tb_work_mem_arbiter.sv
// tb_work_mem_arbiter: table-driven and directed checks of arbitration, locking, timeout and read return.
module tb_work_mem_arbiter;
  logic clk = 1'b0, rst_n, en;
  logic [3:0] valid, wen, lock;
  logic [47:0] addr = {12'h470, 12'h360, 12'h250, 12'h140};
  logic [127:0] wdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
  logic cs1, we1, busy1, to1, cs3, we3, busy3, to3;
  logic [11:0] sa1, sa3, a1;
  logic [11:0] a3 [3];
  logic [31:0] wd1, wd3, rd1, rd3;
  logic [2:0] gid1, gid3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  work_mem_arbiter_if #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(32)) if1 ();
  work_mem_arbiter_if #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(32)) if3 ();
  assign if1.req_valid = valid;
  assign if1.req_wen   = wen;
  assign if1.req_lock  = lock;
  assign if1.req_addr  = addr;
  assign if1.req_wdata = wdata;
  assign if3.req_valid = valid;
  assign if3.req_wen   = wen;
  assign if3.req_lock  = lock;
  assign if3.req_addr  = addr;
  assign if3.req_wdata = wdata;
  work_mem_arbiter #(.RD_LAT(1)) d1 (
    .clk(clk), .rst_n(rst_n), .arb_enable(en), .bus(if1), .sram_cs(cs1), .sram_we(we1),
    .sram_addr(sa1), .sram_wdata(wd1), .sram_rdata(rd1), .arb_busy(busy1),
    .grant_id(gid1), .lock_timeout(to1));
  work_mem_arbiter #(.RD_LAT(3)) d3 (
    .clk(clk), .rst_n(rst_n), .arb_enable(en), .bus(if3), .sram_cs(cs3), .sram_we(we3),
    .sram_addr(sa3), .sram_wdata(wd3), .sram_rdata(rd3), .arb_busy(busy3),
    .grant_id(gid3), .lock_timeout(to3));
  // SRAM models return addr+0x1000 after their respective latencies
  always_ff @(posedge clk) begin
    a1 <= sa1;
    a3[0] <= sa3;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign rd1 = 32'h1000 + {20'h0, a1};
  assign rd3 = 32'h1000 + {20'h0, a3[2]};
  typedef struct {
    logic [3:0] valid, wen;
    logic en;
    logic [3:0] ready;
    logic cs, we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [3:0] rsp;
    logic [31:0] rdata;
    logic [2:0] gid;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [3:0] c_valid [8] = '{4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0};
  logic [3:0] c_rsp1  [8] = '{4'b0, 4'b0100, 4'b0001, 4'b0, 4'b0100, 4'b0, 4'b0, 4'b0};
  logic [31:0] c_rd1  [8] = '{0, 32'h1360, 32'h1140, 0, 32'h1360, 0, 0, 0};
  logic [3:0] c_rsp3  [8] = '{4'b0, 4'b0, 4'b0, 4'b0100, 4'b0001, 4'b0, 4'b0100, 4'b0};
  logic [31:0] c_rd3  [8] = '{0, 0, 0, 32'h1360, 32'h1140, 0, 32'h1360, 0};
  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 12'h140, 32'hD000_0000, 4'b0000, 32'h0,    3'd0};
    tbl[1] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 12'h000, 32'h0,         4'b0001, 32'h1140, 3'd0};
    tbl[2] = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 12'h250, 32'hD000_0001, 4'b0000, 32'h0,    3'd0};
    tbl[3] = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 12'h360, 32'hD000_0002, 4'b0010, 32'h1250, 3'd1};
    tbl[4] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 12'h470, 32'hD000_0003, 4'b0100, 32'h1360, 3'd2};
    tbl[5] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 12'h140, 32'hD000_0000, 4'b1000, 32'h1470, 3'd3};
    tbl[6] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 12'h250, 32'hD000_0001, 4'b0001, 32'h1140, 3'd0};
    tbl[7] = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 12'h000, 32'h0,         4'b0000, 32'h0,    3'd1};
    tbl[8] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 12'h470, 32'hD000_0003, 4'b0000, 32'h0,    3'd1};
    tbl[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 12'h000, 32'h0,         4'b1000, 32'h1470, 3'd3};
    rst_n = 1'b0; en = 1'b0; valid = '0; wen = '0; lock = '0;
    #12;
    chk("reset_ready", {28'h0, if1.req_ready}, 0);
    chk("reset_rsp", {28'h0, if1.rsp_valid}, 0);
    chk("reset_rdata", if1.rsp_rdata, 0);
    chk("reset_sram", {cs1, we1, sa1, wd1 != 0}, 0);
    chk("reset_regs", {busy1, gid1, to1}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid = tbl[i].valid; wen = tbl[i].wen; en = tbl[i].en; lock = '0;
      #2;
      chk($sformatf("v%0d_ready1", i), {28'h0, if1.req_ready}, {28'h0, tbl[i].ready});
      chk($sformatf("v%0d_ready3", i), {28'h0, if3.req_ready}, {28'h0, tbl[i].ready});
      chk($sformatf("v%0d_cs_we", i), {30'h0, cs1, we1}, {30'h0, tbl[i].cs, tbl[i].we});
      chk($sformatf("v%0d_addr", i), {20'h0, sa1}, {20'h0, tbl[i].addr});
      chk($sformatf("v%0d_wdata", i), wd1, tbl[i].wd);
      chk($sformatf("v%0d_rsp", i), {28'h0, if1.rsp_valid}, {28'h0, tbl[i].rsp});
      chk($sformatf("v%0d_rdata", i), if1.rsp_rdata, tbl[i].rdata);
      chk($sformatf("v%0d_gid", i), {29'h0, gid1}, {29'h0, tbl[i].gid});
      tick();
    end
    for (int i = 0; i <= 10; i++) begin
      valid = 4'b1111; wen = 4'b1111; en = 1'b1; lock = (i < 9) ? 4'b0001 : 4'b0000;
      #2;
      chk($sformatf("lock%0d_ready", i), {28'h0, if1.req_ready}, (i < 10) ? 32'h1 : 32'h2);
      if (i == 1) chk("lock_busy", {31'h0, busy1}, 1);
      if (i == 10) chk("unlock_busy", {31'h0, busy1}, 0);
      tick();
    end
    for (int c = 0; c <= 65; c++) begin
      valid = 4'b1111; wen = 4'b1111; lock = 4'b0100; en = !(c >= 30 && c < 40);
      #2;
      chk($sformatf("to%0d_ready", c), {28'h0, if1.req_ready},
          (c >= 30 && c < 40) ? 32'h0 : (c <= 64) ? 32'h4 : 32'h8);
      if (c == 0 || c == 64) chk($sformatf("to%0d_flag", c), {31'h0, to1}, 0);
      if (c == 65) chk("to65_flag", {31'h0, to1}, 1);
      tick();
    end
    for (int t = 0; t < 8; t++) begin
      valid = c_valid[t]; wen = (t == 2) ? 4'b0010 : 4'b0000; lock = '0; en = 1'b1;
      #2;
      chk($sformatf("il%0d_rsp1", t), {28'h0, if1.rsp_valid}, {28'h0, c_rsp1[t]});
      chk($sformatf("il%0d_rd1", t), if1.rsp_rdata, c_rd1[t]);
      chk($sformatf("il%0d_rsp3", t), {28'h0, if3.rsp_valid}, {28'h0, c_rsp3[t]});
      chk($sformatf("il%0d_rd3", t), if3.rsp_rdata, c_rd3[t]);
      tick();
    end
    chk("timeout_sticky", {31'h0, to1}, 1);
    valid = 4'b0001; wen = '0;
    tick();
    valid = 4'b0010;
    tick();
    valid = '0;
    #1;
    chk("inflight_busy", {31'h0, busy3}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp3", {28'h0, if3.rsp_valid, busy3, to3, gid3 != 0}, 0);
    chk("rst_regs1", {28'h0, busy1, to1, gid1 != 0, cs1}, 0);
    chk("rst_ready", {24'h0, if1.req_ready, if3.req_ready}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #2;
      chk($sformatf("post_rst%0d_rsp", t), {24'h0, if1.rsp_valid, if3.rsp_valid}, 0);
      tick();
    end
    valid = 4'b1111; en = 1'b0;
    #2;
    chk("disabled_ready", {24'h0, if1.req_ready, if3.req_ready}, 0);
    chk("disabled_cs", {30'h0, cs1, cs3}, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
